// File: rtl/euclid_pkg.sv
// rtl/euclid_pkg.sv - shared types, CONTROL encodings and width helper for the Euclid sequencer
package euclid_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DIV  = 3'd2,
    S_MUL  = 3'd3,
    S_SWAP = 3'd4,
    S_FIN  = 3'd5
  } euclid_state_t;

  // CONTROL: bit0 shift enable, bits[2:1] A/C select, bits[4:3] B/D select.
  // FIN drives the same word as IDLE, so no separate constant is kept.
  localparam logic [4:0] CTRL_IDLE = 5'b00000;
  localparam logic [4:0] CTRL_LOAD = 5'b00110;
  localparam logic [4:0] CTRL_DIV  = 5'b01000;
  localparam logic [4:0] CTRL_MUL  = 5'b10001;
  localparam logic [4:0] CTRL_SWAP = 5'b11011;

  // ITER must hold 0..2T.
  function automatic int iter_w(input int t);
    return $clog2(2 * t + 1);
  endfunction

endpackage

// File: rtl/euclid_step_counter.sv
// rtl/euclid_step_counter.sv - loadable, clearable up-counter with terminal-count compare
module euclid_step_counter #(
  parameter int WIDTH = 3,
  parameter int TERM  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear beats load, load beats increment.
  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (load_i) count_d = load_val_i;
    else if (inc_i)  count_d = count_q + WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign term_o = (count_q == WIDTH'(TERM));

endmodule

// File: rtl/euclid_sequencer.sv
// rtl/euclid_sequencer.sv - Euclidean key-equation control sequencer; optional EUCLID_CYCLE_COUNT_EN adds cycle_count_o
module euclid_sequencer
  import euclid_pkg::*;
#(
  parameter int T           = 2,
  parameter int DEG_W       = 4,
  parameter int LOAD_CYCLES = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DEG_W-1:0]     deg_r_i,
  input  logic [DEG_W-1:0]     deg_q_i,
  input  logic                 r_zero_i,
  output logic [4:0]           control_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [iter_w(T)-1:0] iter_o
`ifdef EUCLID_CYCLE_COUNT_EN
  ,
  output logic [15:0]          cycle_count_o
`endif
);

  localparam int IW = iter_w(T);
  // Step counter must reach 2T+1 so the watchdog can see it.
  localparam int SW = $clog2(2 * T + 2);
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  euclid_state_t state_q, state_d;
  logic          fin_fail;
  logic          ld_term, ld_clr, ld_inc;
  logic          step_term, step_clr, step_inc;

  logic [4:0]    control_d;
  logic          busy_d, done_d, fail_d;
  logic [IW-1:0] iter_d, iter_q;
  logic          quot_done;

  assign quot_done = r_zero_i || (deg_r_i < deg_q_i);

  // Load counter paces LOAD; restarted on every entry so an aborting START gets a full load.
  assign ld_inc = (state_q == S_LOAD) && !ld_term;
  assign ld_clr = (state_q != S_LOAD) || ld_term || start_i;

  euclid_step_counter #(.WIDTH(LW), .TERM(LOAD_CYCLES - 1)) u_load_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (ld_clr),
    .load_i     (1'b0),
    .load_val_i ({LW{1'b0}}),
    .inc_i      (ld_inc),
    .term_o     (ld_term)
  );

  // Step counter counts quotient steps within one iteration; term flags the watchdog limit.
  assign step_inc = (state_q == S_DIV) && (state_d == S_MUL);
  assign step_clr = start_i || (state_q == S_SWAP) || (state_q == S_IDLE);

  euclid_step_counter #(.WIDTH(SW), .TERM(2 * T + 1)) u_step_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (step_clr),
    .load_i     (1'b0),
    .load_val_i ({SW{1'b0}}),
    .inc_i      (step_inc),
    .term_o     (step_term)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; fin_fail qualifies every entry into FIN.
  always_comb begin
    state_d  = state_q;
    fin_fail = 1'b0;
    if (start_i) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: state_d = ld_term ? S_DIV : S_LOAD;
        S_DIV: begin
          if (quot_done) begin
            state_d = S_SWAP;
          end else if (step_term) begin
            state_d  = S_FIN;
            fin_fail = 1'b1;
          end else begin
            state_d = S_MUL;
          end
        end
        S_MUL: state_d = S_DIV;
        S_SWAP: begin
          if (r_zero_i || (deg_r_i < DEG_W'(T))) begin
            state_d = S_FIN;
          end else if ((iter_q + IW'(1)) == IW'(2 * T)) begin
            state_d  = S_FIN;
            fin_fail = 1'b1;
          end else begin
            state_d = S_DIV;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output next-values, derived from the state being entered so outputs stay registered.
  always_comb begin
    control_d = CTRL_IDLE;
    case (state_d)
      S_LOAD:  control_d = CTRL_LOAD;
      S_DIV:   control_d = CTRL_DIV;
      S_MUL:   control_d = CTRL_MUL;
      S_SWAP:  control_d = CTRL_SWAP;
      default: control_d = CTRL_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_DIV) ||
             (state_d == S_MUL)  || (state_d == S_SWAP);
    done_d = (state_d == S_FIN);
    iter_d = iter_q;
    fail_d = fail_o;
    if (start_i) begin
      iter_d = '0;
      fail_d = 1'b0;
    end else begin
      if (state_q == S_SWAP) iter_d = iter_q + IW'(1);
      if (state_d == S_FIN)  fail_d = fin_fail;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      control_o <= CTRL_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      fail_o    <= 1'b0;
      iter_q    <= '0;
    end else begin
      control_o <= control_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      fail_o    <= fail_d;
      iter_q    <= iter_d;
    end
  end

  assign iter_o = iter_q;

`ifdef EUCLID_CYCLE_COUNT_EN
  logic [15:0] cycle_q;

  // Busy-cycle counter, saturating, held between runs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           cycle_q <= '0;
    else if (start_i)                      cycle_q <= '0;
    else if (busy_o && cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
  end

  assign cycle_count_o = cycle_q;
`endif

endmodule

// File: tb/tb_euclid_sequencer.sv
// tb/tb_euclid_sequencer.sv - directed self-checking bench for euclid_sequencer
module tb_euclid_sequencer;

  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_LOAD = 5'b00110;
  localparam logic [4:0] C_DIV  = 5'b01000;
  localparam logic [4:0] C_MUL  = 5'b10001;
  localparam logic [4:0] C_SWAP = 5'b11011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] deg_r, deg_q;
  logic       r_zero;
  logic [4:0] control;
  logic       busy, done, fail;
  logic [2:0] iter;
`ifdef EUCLID_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int errors = 0;
  int checks = 0;
  // {control, busy, done, fail, iter}
  logic [10:0] obs, exp;

  always #5 clk = ~clk;

  euclid_sequencer #(.T(2), .DEG_W(4), .LOAD_CYCLES(3)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .deg_r_i  (deg_r),
    .deg_q_i  (deg_q),
    .r_zero_i (r_zero),
    .control_o(control),
    .busy_o   (busy),
    .done_o   (done),
    .fail_o   (fail),
    .iter_o   (iter)
`ifdef EUCLID_CYCLE_COUNT_EN
    ,
    .cycle_count_o(cycle_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first DIV cycle.
  task automatic go_to_div();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; deg_r = 4'd0; deg_q = 4'd0; r_zero = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp = {C_IDLE, 3'b000, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, exp); end
  endtask

  task automatic test_load();
    deg_r = 4'd0; deg_q = 4'd0; r_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {C_LOAD, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_cycle%0d: got %b expected %b", i, obs, exp); end
      if (i < 2) tick();
    end
    tick();
    exp = {C_DIV, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL load_to_div: got %b expected %b", obs, exp); end
  endtask

  task automatic test_single_iter();
    deg_q = 4'd4; deg_r = 4'd4; r_zero = 1'b0;
    go_to_div();
    tick();
    exp = {C_MUL, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_mul: got %b expected %b", obs, exp); end
    deg_r = 4'd3;
    tick();
    exp = {C_DIV, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_div2: got %b expected %b", obs, exp); end
    tick();
    exp = {C_SWAP, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_swap: got %b expected %b", obs, exp); end
    deg_r = 4'd1;
    tick();
    exp = {C_IDLE, 3'b010, 3'd1}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_fin: got %b expected %b", obs, exp); end
    tick();
    exp = {C_IDLE, 3'b000, 3'd1}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_idle_hold: got %b expected %b", obs, exp); end
  endtask

  task automatic test_iter_limit();
    deg_q = 4'd3; deg_r = 4'd2; r_zero = 1'b0;
    go_to_div();
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {C_SWAP, 3'b100, 3'(i)}; obs = {control, busy, done, fail, iter}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL iter_swap%0d: got %b expected %b", i, obs, exp); end
      if (i < 3) begin
        tick();
        exp = {C_DIV, 3'b100, 3'(i + 1)}; obs = {control, busy, done, fail, iter}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL iter_div%0d: got %b expected %b", i, obs, exp); end
      end
    end
    tick();
    exp = {C_IDLE, 3'b011, 3'd4}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL iter_fin: got %b expected %b", obs, exp); end
    tick();
    exp = {C_IDLE, 3'b001, 3'd4}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL iter_hold: got %b expected %b", obs, exp); end
  endtask

  task automatic test_watchdog();
    deg_r = 4'd4; deg_q = 4'd1; r_zero = 1'b0;
    go_to_div();
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {C_MUL, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL wdog_mul%0d: got %b expected %b", i, obs, exp); end
      tick();
      exp = {C_DIV, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL wdog_div%0d: got %b expected %b", i, obs, exp); end
    end
    tick();
    exp = {C_IDLE, 3'b011, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL wdog_fin: got %b expected %b", obs, exp); end
  endtask

  task automatic test_restart();
    deg_q = 4'd3; deg_r = 4'd2; r_zero = 1'b0;
    go_to_div();
    tick();   // SWAP
    tick();   // DIV, iteration 2
    deg_r = 4'd3;
    tick();
    exp = {C_MUL, 3'b100, 3'd1}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL restart_mul: got %b expected %b", obs, exp); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {C_LOAD, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL restart_load%0d: got %b expected %b", i, obs, exp); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    deg_q = 4'd3; deg_r = 4'd2; r_zero = 1'b0;
    go_to_div();
    tick();   // SWAP
    tick();   // DIV with iter=1
    rst_n = 1'b0;
    #1;
    exp = {C_IDLE, 3'b000, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_reset: got %b expected %b", obs, exp); end
    #1;
    rst_n = 1'b1;
    tick();
    deg_r = 4'd4; deg_q = 4'd1; r_zero = 1'b1;
    go_to_div();
    tick();
    exp = {C_SWAP, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rzero_swap: got %b expected %b", obs, exp); end
    tick();
    exp = {C_IDLE, 3'b010, 3'd1}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rzero_fin: got %b expected %b", obs, exp); end
`ifdef EUCLID_CYCLE_COUNT_EN
    checks++;
    if (cycle_count !== 16'd5) begin errors++; $display("FAIL cycle_count: got %0d expected 5", cycle_count); end
`endif
    // START landing in FIN: DONE already pulsed this cycle, run restarts.
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {C_LOAD, 3'b100, 3'd0}; obs = {control, busy, done, fail, iter}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL fin_restart: got %b expected %b", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single_iter();
    test_iter_limit();
    test_watchdog();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
